// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: per-frame round-robin sharing of one MAC TX client port between two sources
module mac_tx_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             tx_clk,
    input  logic             reset,
    input  logic             arb_en,
    input  logic [7:0]       src0_data,
    input  logic             src0_dvld,
    output logic             src0_ack,
    input  logic [7:0]       src1_data,
    input  logic             src1_dvld,
    output logic             src1_ack,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_dvld,
    input  logic             mac_tx_ack,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt_0,
    output logic [CNT_W-1:0] frame_cnt_1,
    output logic [CNT_W-1:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;
    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             ack_seen_q, ack_seen_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] frame_cnt_0_q, frame_cnt_0_d;
    logic [CNT_W-1:0] frame_cnt_1_q, frame_cnt_1_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             own0, own1, frame_end;
    assign own0      = state_q == GRANT0;
    assign own1      = state_q == GRANT1;
    assign frame_end = (own0 && !src0_dvld) || (own1 && !src1_dvld);
    assign mac_tx_data = own0 ? src0_data : own1 ? src1_data : 8'h00;
    assign mac_tx_dvld = (own0 && src0_dvld) || (own1 && src1_dvld);
    assign src0_ack    = own0 && mac_tx_ack;
    assign src1_ack    = own1 && mac_tx_ack;
    assign grant       = {own1, own0};
    assign busy        = state_q != IDLE;
    assign frame_cnt_0 = frame_cnt_0_q;
    assign frame_cnt_1 = frame_cnt_1_q;
    assign drop_cnt    = drop_cnt_q;
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        ack_seen_d    = ack_seen_q;
        gap_cnt_d     = gap_cnt_q;
        frame_cnt_0_d = frame_cnt_0_q;
        frame_cnt_1_d = frame_cnt_1_q;
        drop_cnt_d    = drop_cnt_q;
        if (state_q == IDLE) begin
            // on contention the source that did not send last wins; last resets to 1 so src0 goes first
            if (arb_en && (src0_dvld || src1_dvld))
                state_d = (src0_dvld && (!src1_dvld || last_q)) ? GRANT0 : GRANT1;
        end else if (state_q == GAP) begin
            state_d   = (gap_cnt_q == 8'(GAP_CYCLES - 1)) ? IDLE : GAP;
            gap_cnt_d = (gap_cnt_q == 8'(GAP_CYCLES - 1)) ? 8'd0 : gap_cnt_q + 8'd1;
        end else if (frame_end) begin
            state_d       = GAP;
            last_d        = own1;
            ack_seen_d    = 1'b0;
            gap_cnt_d     = 8'd0;
            frame_cnt_0_d = (ack_seen_q && own0) ? frame_cnt_0_q + CNT_W'(1) : frame_cnt_0_q;
            frame_cnt_1_d = (ack_seen_q && own1) ? frame_cnt_1_q + CNT_W'(1) : frame_cnt_1_q;
            drop_cnt_d    = ack_seen_q ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
        end else begin
            ack_seen_d = ack_seen_q || mac_tx_ack;
        end
    end
    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            ack_seen_q    <= 1'b0;
            gap_cnt_q     <= 8'd0;
            frame_cnt_0_q <= '0;
            frame_cnt_1_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            ack_seen_q    <= ack_seen_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_cnt_0_q <= frame_cnt_0_d;
            frame_cnt_1_q <= frame_cnt_1_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: random two-source traffic against a transaction-level arbiter model
module tb_mac_tx_arbiter;
    localparam int GAP    = 2;
    localparam int CYCLES = 20000;
    logic        tx_clk = 1'b0;
    logic        reset = 1'b1, arb_en = 1'b1;
    logic [7:0]  src0_data = 8'h00, src1_data = 8'h00;
    logic        src0_dvld = 1'b0, src1_dvld = 1'b0, mac_tx_ack = 1'b0;
    logic        src0_ack, src1_ack, mac_tx_dvld, busy;
    logic [7:0]  mac_tx_data;
    logic [1:0]  grant;
    logic [15:0] frame_cnt_0, frame_cnt_1, drop_cnt;
    logic        w_src0_ack, w_src1_ack, w_mac_tx_dvld, w_busy;
    logic [7:0]  w_mac_tx_data;
    logic [1:0]  w_grant;
    logic [3:0]  w_frame_cnt_0, w_frame_cnt_1, w_drop_cnt;
    mac_tx_arbiter #(.GAP_CYCLES(GAP), .CNT_W(16)) dut (
        .tx_clk(tx_clk), .reset(reset), .arb_en(arb_en),
        .src0_data(src0_data), .src0_dvld(src0_dvld), .src0_ack(src0_ack),
        .src1_data(src1_data), .src1_dvld(src1_dvld), .src1_ack(src1_ack),
        .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
        .grant(grant), .busy(busy),
        .frame_cnt_0(frame_cnt_0), .frame_cnt_1(frame_cnt_1), .drop_cnt(drop_cnt)
    );
    mac_tx_arbiter #(.GAP_CYCLES(GAP), .CNT_W(4)) dut4 (
        .tx_clk(tx_clk), .reset(reset), .arb_en(arb_en),
        .src0_data(src0_data), .src0_dvld(src0_dvld), .src0_ack(w_src0_ack),
        .src1_data(src1_data), .src1_dvld(src1_dvld), .src1_ack(w_src1_ack),
        .mac_tx_data(w_mac_tx_data), .mac_tx_dvld(w_mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
        .grant(w_grant), .busy(w_busy),
        .frame_cnt_0(w_frame_cnt_0), .frame_cnt_1(w_frame_cnt_1), .drop_cnt(w_drop_cnt)
    );
    always #5 tx_clk = ~tx_clk;
    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // model: owner -1 = nobody, hold = forced idle cycles left after a frame
    int owner, hold, last, acked, cnt0, cnt1, drops, wcnt, ack_dly;
    int s[2], rem[2], len[2], wt[2], tmo[2], idle[2];
    logic [7:0] byte_q[2];
    task automatic model_reset();
        owner = -1; hold = 0; last = 1; acked = 0;
        cnt0 = 0; cnt1 = 0; drops = 0; wcnt = 0; ack_dly = 0;
        for (int n = 0; n < 2; n++) begin
            s[n] = 0; rem[n] = 0; wt[n] = 0; idle[n] = 0;
        end
    endtask
    initial begin
        logic [1:0] dv, ack_n;
        logic [7:0] exp_data;
        logic       did_mid;
        did_mid = 1'b0;
        model_reset();
        repeat (2) @(posedge tx_clk);
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge tx_clk);
            reset  = ($urandom_range(2999) == 0) || (!did_mid && cyc > 5000 && owner >= 0);
            if (reset && owner >= 0) did_mid = 1'b1;
            arb_en = ($urandom_range(149) == 0) ? !arb_en : arb_en;
            for (int n = 0; n < 2; n++)
                if (s[n] != 1) byte_q[n] = 8'($urandom);
            src0_dvld = s[0] != 0; src0_data = byte_q[0];
            src1_dvld = s[1] != 0; src1_data = byte_q[1];
            dv = {src1_dvld, src0_dvld};
            mac_tx_ack = (owner >= 0) ? (dv[owner] && acked == 0 && wcnt == ack_dly)
                                      : ($urandom_range(19) == 0);
            exp_data = (owner == 0) ? src0_data : (owner == 1) ? src1_data : 8'h00;
            #1;
            check("mac_tx_data", 32'(mac_tx_data), 32'(exp_data));
            check("mac_tx_dvld", 32'(mac_tx_dvld), 32'(owner >= 0 && dv[owner]));
            check("src0_ack", 32'(src0_ack), 32'(owner == 0 && mac_tx_ack));
            check("src1_ack", 32'(src1_ack), 32'(owner == 1 && mac_tx_ack));
            check("grant", 32'(grant), (owner == 0) ? 1 : (owner == 1) ? 2 : 0);
            check("busy", 32'(busy), 32'(owner >= 0 || hold > 0));
            check("frame_cnt_0", 32'(frame_cnt_0), cnt0 & 16'hFFFF);
            check("frame_cnt_1", 32'(frame_cnt_1), cnt1 & 16'hFFFF);
            check("drop_cnt", 32'(drop_cnt), drops & 16'hFFFF);
            check("w4_grant", 32'(w_grant), (owner == 0) ? 1 : (owner == 1) ? 2 : 0);
            check("w4_frame_cnt_0", 32'(w_frame_cnt_0), cnt0 & 15);
            check("w4_frame_cnt_1", 32'(w_frame_cnt_1), cnt1 & 15);
            check("w4_drop_cnt", 32'(w_drop_cnt), drops & 15);
            @(posedge tx_clk);
            ack_n = {owner == 1 && mac_tx_ack, owner == 0 && mac_tx_ack};
            if (reset) begin
                model_reset();
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (s[n] == 0) begin
                        if (idle[n] > 0) idle[n]--;
                        else if ($urandom_range(3) == 0) begin
                            s[n] = 1; wt[n] = 0; tmo[n] = $urandom_range(60, 8);
                            len[n] = ($urandom_range(9) == 0) ? 64 : $urandom_range(24, 1);
                        end
                    end else if (s[n] == 1) begin
                        wt[n]++;
                        if (ack_n[n]) begin
                            s[n] = 2; rem[n] = len[n];
                        end else if (wt[n] >= tmo[n]) begin
                            s[n] = 0; idle[n] = $urandom_range(3);
                        end
                    end else begin
                        rem[n]--;
                        if (rem[n] == 0) begin
                            s[n] = 0; idle[n] = $urandom_range(3);
                        end
                    end
                end
                if (owner >= 0) begin
                    wcnt++;
                    if (!dv[owner]) begin
                        if (acked != 0) begin
                            if (owner == 0) cnt0++; else cnt1++;
                        end else drops++;
                        last = owner; owner = -1; acked = 0; hold = GAP;
                    end else if (mac_tx_ack) acked = 1;
                end else if (hold > 0) begin
                    hold--;
                end else if (arb_en && dv != 2'b00) begin
                    owner = (dv == 2'b11) ? 1 - last : (dv[0] ? 0 : 1);
                    wcnt = 0;
                    ack_dly = ($urandom_range(9) == 0) ? 255 : $urandom_range(6);
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
